// File: rtl/pix_palette_mem_if.sv
// Pixel request/response bundle for pix_palette_mem: request fields flow from
// the display timing side to the block; coloured pixel results flow back.
interface pix_palette_mem_if #(
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8
);
  logic               i_valid;
  logic [ADDR_W-1:0]  i_vga_addr;
  logic               i_mode;
  logic               o_valid;
  logic [COLOR_W-1:0] o_red;
  logic [COLOR_W-1:0] o_green;
  logic [COLOR_W-1:0] o_blue;

  modport master (
    output i_valid, i_vga_addr, i_mode,
    input  o_valid, o_red, o_green, o_blue
  );

  modport slave (
    input  i_valid, i_vga_addr, i_mode,
    output o_valid, o_red, o_green, o_blue
  );
endinterface

// File: rtl/pix_palette_mem.sv
// Packed-pixel framebuffer reader: unpacks BPP-bit fields from ROM words and
// maps them to RGB by grey expansion or a writable palette, fixed 3-cycle latency.
module pix_palette_mem #(
  parameter int ADDR_W  = 19,
  parameter int BPP     = 1,
  parameter int ROM_W   = 8,
  parameter int COLOR_W = 8,
  localparam int PPW     = ROM_W / BPP,
  localparam int LOG_PPW = $clog2(PPW),
  localparam int SEL_W   = (LOG_PPW < 1) ? 1 : LOG_PPW
) (
  input  logic                      i_vga_clk,
  input  logic                      rst,
  pix_palette_mem_if.slave          pix,
  output logic [ADDR_W-LOG_PPW-1:0] o_rom_addr,
  input  logic [ROM_W-1:0]          i_rom_data,
  input  logic                      i_pal_we,
  input  logic [BPP-1:0]            i_pal_addr,
  input  logic [3*COLOR_W-1:0]      i_pal_data
);

  generate
    if (!(BPP == 1 || BPP == 2 || BPP == 4 || BPP == 8) || ROM_W < BPP ||
        (ROM_W & (ROM_W - 1)) != 0 || COLOR_W < BPP || ADDR_W <= LOG_PPW) begin : g_bad_cfg
      $error("pix_palette_mem: illegal BPP/ROM_W/COLOR_W/ADDR_W combination");
    end
  endgenerate

  // Pixel 0 of a word sits in the most significant BPP bits.
  function automatic logic [BPP-1:0] pick_field(input logic [ROM_W-1:0] word,
                                                input logic [SEL_W-1:0] sel);
    logic [ROM_W-1:0] sh;
    sh = word << (int'(sel) * BPP);
    return sh[ROM_W-1 -: BPP];
  endfunction

  // Repeat the field MSB-first across the channel so full-scale maps to all ones.
  function automatic logic [COLOR_W-1:0] grey(input logic [BPP-1:0] f);
    logic [COLOR_W-1:0] g;
    for (int i = 0; i < COLOR_W; i++) g[COLOR_W-1-i] = f[BPP-1-(i % BPP)];
    return g;
  endfunction

  logic                 vld_p1_q, mode_p1_q;
  logic [SEL_W-1:0]     sel_p1_d, sel_p1_q;
  logic                 vld_p2_q, mode_p2_q;
  logic [BPP-1:0]       field_p2_d, field_p2_q;
  logic                 vld_p3_q;
  logic [3*COLOR_W-1:0] rgb_p3_d, rgb_p3_q;
  logic [3*COLOR_W-1:0] pal_q [2**BPP];

  assign o_rom_addr = pix.i_vga_addr[ADDR_W-1:LOG_PPW];

  generate
    if (LOG_PPW == 0) begin : g_one_ppw
      assign sel_p1_d = '0;
    end else begin : g_multi_ppw
      assign sel_p1_d = pix.i_vga_addr[SEL_W-1:0];
    end
  endgenerate

  always_comb begin
    field_p2_d = pick_field(i_rom_data, sel_p1_q);
    rgb_p3_d   = '0;
    if (vld_p2_q) begin
      // Palette read sees the pre-write value when a write lands on the same edge.
      rgb_p3_d = mode_p2_q ? pal_q[field_p2_q] : {3{grey(field_p2_q)}};
    end
  end

  always_ff @(posedge i_vga_clk) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      mode_p1_q  <= 1'b0;
      sel_p1_q   <= '0;
      vld_p2_q   <= 1'b0;
      mode_p2_q  <= 1'b0;
      field_p2_q <= '0;
      vld_p3_q   <= 1'b0;
      rgb_p3_q   <= '0;
      for (int k = 0; k < 2**BPP; k++) pal_q[k] <= {3{grey(BPP'(k))}};
    end else begin
      // p1: request capture
      vld_p1_q   <= pix.i_valid;
      mode_p1_q  <= pix.i_mode;
      sel_p1_q   <= sel_p1_d;
      // p2: field extraction from returned ROM word
      vld_p2_q   <= vld_p1_q;
      mode_p2_q  <= mode_p1_q;
      field_p2_q <= field_p2_d;
      // p3: colour output
      vld_p3_q   <= vld_p2_q;
      rgb_p3_q   <= rgb_p3_d;
      if (i_pal_we) pal_q[i_pal_addr] <= i_pal_data;
    end
  end

  assign pix.o_valid = vld_p3_q;
  assign pix.o_red   = rgb_p3_q[3*COLOR_W-1:2*COLOR_W];
  assign pix.o_green = rgb_p3_q[2*COLOR_W-1:COLOR_W];
  assign pix.o_blue  = rgb_p3_q[COLOR_W-1:0];

endmodule

// File: tb/tb_pix_palette_mem.sv
// Scoreboard bench for pix_palette_mem: a 1-bpp and a 2-bpp instance share
// clock and reset; expected pixels are queued with their due cycle.
module tb_pix_palette_mem;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pix_palette_mem_if #(.ADDR_W(AW), .COLOR_W(8)) pix1 ();
  pix_palette_mem_if #(.ADDR_W(AW), .COLOR_W(8)) pix2 ();

  logic [4:0]  rom_addr1;
  logic [7:0]  rom_data1;
  logic [5:0]  rom_addr2;
  logic [7:0]  rom_data2;
  logic        pal_we1, pal_we2;
  logic [0:0]  pal_addr1;
  logic [1:0]  pal_addr2;
  logic [23:0] pal_data1, pal_data2;
  logic [7:0]  rom1 [32];
  logic [7:0]  rom2 [64];

  always @(posedge clk) begin
    rom_data1 <= rom1[rom_addr1];
    rom_data2 <= rom2[rom_addr2];
  end

  pix_palette_mem #(.ADDR_W(AW), .BPP(1), .ROM_W(8), .COLOR_W(8)) dut1 (
    .i_vga_clk(clk), .rst(rst), .pix(pix1),
    .o_rom_addr(rom_addr1), .i_rom_data(rom_data1),
    .i_pal_we(pal_we1), .i_pal_addr(pal_addr1), .i_pal_data(pal_data1)
  );

  pix_palette_mem #(.ADDR_W(AW), .BPP(2), .ROM_W(8), .COLOR_W(8)) dut2 (
    .i_vga_clk(clk), .rst(rst), .pix(pix2),
    .o_rom_addr(rom_addr2), .i_rom_data(rom_data2),
    .i_pal_we(pal_we2), .i_pal_addr(pal_addr2), .i_pal_data(pal_data2)
  );

  typedef struct {
    int          due;
    logic [23:0] rgb;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string nm, input logic gv, input logic [23:0] grgb,
                       input logic ev, input logic [23:0] ergb);
    total++;
    if (gv !== ev || grgb !== ergb) begin
      bad++;
      $display("FAIL %s cyc=%0d got valid=%b rgb=%h expected valid=%b rgb=%h",
               nm, cyc, gv, grgb, ev, ergb);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e = q1.pop_front();
        check("dut1_pixel", pix1.o_valid, {pix1.o_red, pix1.o_green, pix1.o_blue}, 1'b1, e.rgb);
      end else begin
        check("dut1_blank", pix1.o_valid, {pix1.o_red, pix1.o_green, pix1.o_blue}, 1'b0, 24'h0);
      end
      if (q2.size() > 0 && q2[0].due == cyc) begin
        e = q2.pop_front();
        check("dut2_pixel", pix2.o_valid, {pix2.o_red, pix2.o_green, pix2.o_blue}, 1'b1, e.rgb);
      end else begin
        check("dut2_blank", pix2.o_valid, {pix2.o_red, pix2.o_green, pix2.o_blue}, 1'b0, 24'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic v, input int a, input logic m, input logic [23:0] e);
    pix1.i_valid    = v;
    pix1.i_vga_addr = AW'(a);
    pix1.i_mode     = m;
    if (v && !rst) q1.push_back('{due: cyc + 3, rgb: e});
  endtask

  task automatic drv2(input logic v, input int a, input logic m, input logic [23:0] e);
    pix2.i_valid    = v;
    pix2.i_vga_addr = AW'(a);
    pix2.i_mode     = m;
    if (v && !rst) q2.push_back('{due: cyc + 3, rgb: e});
  endtask

  task automatic flush_inflight();
    while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
    while (q2.size() > 0 && q2[$].due > cyc) void'(q2.pop_back());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got no finish expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] e33 [8];
    logic [23:0] e34 [4];
    e33 = '{24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    e34 = '{24'hFFFFFF, 24'hAAAAAA, 24'h555555, 24'h000000};

    for (int i = 0; i < 32; i++) rom1[i] = 8'h00;
    for (int i = 0; i < 64; i++) rom2[i] = 8'h00;
    rom1[0] = 8'b1010_0000;
    rom2[0] = 8'b11_10_01_00;
    rom2[1] = 8'b10_10_10_10;

    rst = 1'b1;
    pal_we1 = 1'b0; pal_addr1 = '0; pal_data1 = '0;
    pal_we2 = 1'b0; pal_addr2 = '0; pal_data2 = '0;
    drv1(0, 0, 0, 0);
    drv2(0, 0, 0, 0);
    step();
    mon_en = 1'b1;
    step();
    step();
    rst = 1'b0;

    // 1bpp grey sweep of one word, 2bpp grey sweep alongside
    for (int i = 0; i < 8; i++) begin
      drv1(1, i, 0, e33[i]);
      if (i < 4) drv2(1, i, 0, e34[i]);
      else       drv2(0, 0, 0, 0);
      step();
    end
    drv1(0, 0, 0, 0);
    drv2(0, 0, 0, 0);
    repeat (4) step();

    // blanking gap, then reset-default palette in mode 1
    drv1(1, 0, 0, 24'hFFFFFF); step();
    drv1(0, 1, 0, 24'h0);      step();
    drv1(1, 2, 0, 24'hFFFFFF); step();
    drv1(1, 0, 1, 24'hFFFFFF); step();
    drv1(1, 1, 1, 24'h000000); step();
    drv1(0, 0, 0, 0);
    repeat (4) step();

    // palette write colliding with a field-2 lookup in the output stage
    drv2(1, 4, 1, 24'hAAAAAA); step();
    drv2(1, 5, 1, 24'h123456); step();
    pal_we2 = 1'b1; pal_addr2 = 2'd2; pal_data2 = 24'h123456;
    drv2(1, 6, 1, 24'h123456); step();
    pal_we2 = 1'b0;

    // mode switching mid-stream
    drv2(1, 5, 0, 24'hAAAAAA); step();
    drv2(1, 6, 1, 24'h123456); step();
    drv2(1, 1, 1, 24'h123456); step();
    drv2(1, 1, 0, 24'hAAAAAA); step();
    drv2(0, 0, 0, 0);
    repeat (4) step();

    // one-cycle reset in a valid stream, with an ignored palette write
    drv2(1, 4, 1, 24'h123456); step();
    drv2(1, 5, 1, 24'h123456); step();
    rst = 1'b1;
    flush_inflight();
    pal_we2 = 1'b1; pal_addr2 = 2'd1; pal_data2 = 24'hFFFFFF;
    drv2(1, 6, 1, 24'h0);
    step();
    rst = 1'b0;
    pal_we2 = 1'b0;
    drv2(1, 6, 1, 24'hAAAAAA); step();
    drv2(1, 2, 1, 24'h555555); step();
    drv2(1, 7, 0, 24'hAAAAAA); step();
    drv2(0, 0, 0, 0);
    repeat (6) step();

    total++;
    if (q1.size() != 0) begin
      bad++;
      $display("FAIL dut1_drain got pending=%0d expected pending=0", q1.size());
    end
    total++;
    if (q2.size() != 0) begin
      bad++;
      $display("FAIL dut2_drain got pending=%0d expected pending=0", q2.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
